// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - state type and default timing constants for the PLL reset sequencer
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } seq_state_e;

  localparam int unsigned DEF_RESET_HOLD_CYCLES   = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 2048;
  localparam int unsigned DEF_LOCK_FILTER_CYCLES  = 4;
  localparam int unsigned DEF_SETTLE_CYCLES       = 256;
  localparam int unsigned DEF_MAX_RETRIES         = 3;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop single-bit synchronizer, clears to 0 on reset
module sync_2ff (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset/lock sequencing FSM gating the core-domain reset
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RESET_HOLD_CYCLES   = DEF_RESET_HOLD_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned LOCK_FILTER_CYCLES  = DEF_LOCK_FILTER_CYCLES,
  parameter int unsigned SETTLE_CYCLES       = DEF_SETTLE_CYCLES,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic       REFERENCECLK,
  input  logic       RESET,
  input  logic       PLL_LOCK,
  input  logic       REQ_RELOCK,
  output logic       PLL_RESETB,
  output logic       PLL_BYPASS,
  output logic       CORE_RESETN,
  output logic       READY,
  output logic       FAULT,
  output logic       LOCK_LOST,
  output logic [1:0] RETRY_CNT
);

  localparam int unsigned CNT_MAX = max2(max2(RESET_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES),
                                         max2(LOCK_FILTER_CYCLES, SETTLE_CYCLES));
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILT_LAST    = CNT_W'(LOCK_FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  logic lock_s;

  sync_2ff u_lock_sync (
    .clk    (REFERENCECLK),
    .resetn (RESET),
    .d      (PLL_LOCK),
    .q      (lock_s)
  );

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] filt_q, filt_d;
  logic [1:0]       retry_q, retry_d;
  logic             lost_q, lost_d;
  logic             resetb_q, resetb_d;
  logic             bypass_q, bypass_d;
  logic             core_q, core_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;
  logic             fail;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    filt_d  = filt_q;
    retry_d = retry_q;
    lost_d  = 1'b0;
    fail    = 1'b0;

    case (state_q)
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
        else                    cnt_d   = cnt_q + CNT_ONE;
      end
      ST_WAIT_LOCK: begin
        filt_d = lock_s ? filt_q + CNT_ONE : '0;
        cnt_d  = cnt_q + CNT_ONE;
        // A lock qualifying on the timeout cycle still counts as success
        if (lock_s && (filt_q == FILT_LAST)) state_d = ST_SETTLE;
        else if (cnt_q == TIMEOUT_LAST)      fail    = 1'b1;
      end
      ST_SETTLE: begin
        if (!lock_s)                    fail    = 1'b1;
        else if (cnt_q == SETTLE_LAST)  state_d = ST_RUN;
        else                            cnt_d   = cnt_q + CNT_ONE;
      end
      ST_RUN: begin
        if (!lock_s || REQ_RELOCK) begin
          state_d = ST_HOLD;
          lost_d  = !lock_s;
          retry_d = 2'd0;
        end
      end
      ST_FAULT: begin
        if (REQ_RELOCK) begin
          state_d = ST_HOLD;
          retry_d = 2'd0;
        end
      end
      default: state_d = ST_HOLD;
    endcase

    if (fail) begin
      if (32'(retry_q) < MAX_RETRIES) begin
        state_d = ST_HOLD;
        if (retry_q != 2'd3) retry_d = retry_q + 2'd1;
      end else begin
        state_d = ST_FAULT;
      end
    end

    if ((state_d == ST_RUN) && (state_q != ST_RUN)) retry_d = 2'd0;

    if (state_d != state_q) begin
      cnt_d  = '0;
      filt_d = '0;
    end

    // Outputs decode the next state so the registered copies track state_q exactly
    resetb_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_SETTLE) || (state_d == ST_RUN);
    bypass_d = (state_d == ST_FAULT);
    core_d   = (state_d == ST_RUN);
    ready_d  = (state_d == ST_RUN);
    fault_d  = (state_d == ST_FAULT);
  end

  always_ff @(posedge REFERENCECLK) begin
    if (!RESET) begin
      state_q  <= ST_HOLD;
      cnt_q    <= '0;
      filt_q   <= '0;
      retry_q  <= 2'd0;
      lost_q   <= 1'b0;
      resetb_q <= 1'b0;
      bypass_q <= 1'b0;
      core_q   <= 1'b0;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      filt_q   <= filt_d;
      retry_q  <= retry_d;
      lost_q   <= lost_d;
      resetb_q <= resetb_d;
      bypass_q <= bypass_d;
      core_q   <= core_d;
      ready_q  <= ready_d;
      fault_q  <= fault_d;
    end
  end

  assign PLL_RESETB  = resetb_q;
  assign PLL_BYPASS  = bypass_q;
  assign CORE_RESETN = core_q;
  assign READY       = ready_q;
  assign FAULT       = fault_q;
  assign LOCK_LOST   = lost_q;
  assign RETRY_CNT   = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed self-checking bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

  logic       clk;
  logic       rst_n;
  logic       pll_lock;
  logic       req_relock;
  logic       pll_resetb, pll_bypass, core_resetn, ready, fault, lock_lost;
  logic [1:0] retry_cnt;

  int errors = 0;
  int checks = 0;

  pll_reset_sequencer #(
    .RESET_HOLD_CYCLES   (4),
    .LOCK_TIMEOUT_CYCLES (32),
    .LOCK_FILTER_CYCLES  (2),
    .SETTLE_CYCLES       (8),
    .MAX_RETRIES         (2)
  ) dut (
    .REFERENCECLK (clk),
    .RESET        (rst_n),
    .PLL_LOCK     (pll_lock),
    .REQ_RELOCK   (req_relock),
    .PLL_RESETB   (pll_resetb),
    .PLL_BYPASS   (pll_bypass),
    .CORE_RESETN  (core_resetn),
    .READY        (ready),
    .FAULT        (fault),
    .LOCK_LOST    (lock_lost),
    .RETRY_CNT    (retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector: {RESETB, BYPASS, CORE_RESETN, READY, FAULT, LOCK_LOST, RETRY_CNT[1:0]}
  localparam logic [7:0] O_HOLD0  = 8'h00;
  localparam logic [7:0] O_HOLD1  = 8'h01;
  localparam logic [7:0] O_HOLD2  = 8'h02;
  localparam logic [7:0] O_WAIT0  = 8'h80;
  localparam logic [7:0] O_WAIT1  = 8'h81;
  localparam logic [7:0] O_WAIT2  = 8'h82;
  localparam logic [7:0] O_RUN    = 8'hB0;
  localparam logic [7:0] O_LOST   = 8'h04;
  localparam logic [7:0] O_FAULT2 = 8'h4A;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {pll_resetb, pll_bypass, core_resetn, ready, fault, lock_lost, retry_cnt};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    pll_lock   = 1'b0;
    req_relock = 1'b0;

    cyc(3);                 chk("reset_state", O_HOLD0);
    rst_n = 1'b1;
    cyc(3);                 chk("hold_3", O_HOLD0);
    cyc(1);                 chk("wait_entry", O_WAIT0);
    cyc(6);
    pll_lock = 1'b1;
    cyc(11);                chk("settle_end", O_WAIT0);
    cyc(1);                 chk("nominal_run", O_RUN);

    cyc(3);
    pll_lock = 1'b0;
    cyc(2);                 chk("loss_in_sync", O_RUN);
    cyc(1);                 chk("lock_lost", O_LOST);
    cyc(1);                 chk("lost_one_pulse", O_HOLD0);
    cyc(2);                 chk("loss_hold4", O_HOLD0);
    cyc(1);                 chk("loss_wait", O_WAIT0);
    pll_lock = 1'b1;
    cyc(11);                chk("relock_settle", O_WAIT0);
    cyc(1);                 chk("relock_run", O_RUN);

    pll_lock = 1'b0;
    cyc(7);                 chk("glitch_wait", O_WAIT0);
    pll_lock   = 1'b1;
    req_relock = 1'b1;
    cyc(1);
    pll_lock   = 1'b0;
    req_relock = 1'b0;      chk("relock_ignored_wait", O_WAIT0);
    cyc(4);                 chk("glitch_no_settle", O_WAIT0);
    pll_lock = 1'b1;
    cyc(6);
    pll_lock = 1'b0;
    cyc(2);                 chk("settle_before_drop", O_WAIT0);
    cyc(1);                 chk("settle_drop", O_HOLD1);

    cyc(4);                 chk("retry1_wait", O_WAIT1);
    cyc(31);                chk("timeout_edge", O_WAIT1);
    cyc(1);                 chk("timeout_retry2", O_HOLD2);
    cyc(4);                 chk("retry2_wait", O_WAIT2);
    cyc(31);                chk("last_wait", O_WAIT2);
    cyc(1);                 chk("fault_entry", O_FAULT2);
    cyc(5);                 chk("fault_sticky", O_FAULT2);

    req_relock = 1'b1;
    cyc(1);                 chk("fault_relock", O_HOLD0);
    req_relock = 1'b0;
    cyc(4);                 chk("nolock_wait1", O_WAIT0);
    cyc(32);                chk("nolock_retry1", O_HOLD1);
    cyc(4);                 chk("nolock_wait2", O_WAIT1);
    cyc(32);                chk("nolock_retry2", O_HOLD2);
    cyc(4);                 chk("nolock_wait3", O_WAIT2);
    cyc(32);                chk("nolock_fault", O_FAULT2);

    req_relock = 1'b1;
    pll_lock   = 1'b1;
    cyc(1);                 chk("fault_relock2", O_HOLD0);
    req_relock = 1'b0;
    cyc(9);                 chk("mid_settle", O_WAIT0);
    rst_n = 1'b0;
    cyc(1);                 chk("reset_mid_settle", O_HOLD0);
    rst_n = 1'b1;
    cyc(3);                 chk("hold_restart", O_HOLD0);
    cyc(1);                 chk("restart_wait", O_WAIT0);
    cyc(9);                 chk("restart_settle", O_WAIT0);
    cyc(1);                 chk("restart_run", O_RUN);

    pll_lock = 1'b0;
    cyc(2);
    req_relock = 1'b1;
    cyc(1);                 chk("loss_and_relock", O_LOST);
    req_relock = 1'b0;
    cyc(1);                 chk("loss_relock_hold", O_HOLD0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameter RESET_HOLD_CYCLES, default 16: cycles PLL_RESETB is held low per attempt (>=1).
REQ-002 Parameter LOCK_TIMEOUT_CYCLES, default 2048: maximum cycles in WAIT_LOCK per attempt.
REQ-003 Parameter LOCK_FILTER_CYCLES, default 4: consecutive synchronized-lock-high cycles needed to qualify lock (>=1).
REQ-004 Parameter SETTLE_CYCLES, default 256: cycles lock must stay high before CORE_RESETN is released.
REQ-005 Parameter MAX_RETRIES, default 3: timed-out or dropped attempts tolerated before FAULT.
REQ-006 REFERENCECLK  in  1  sole clock (PLL reference); all logic is on its rising edge.
REQ-007 RESET  in  1  reset, synchronous, active-low.
REQ-008 PLL_LOCK  in  1  PLL LOCK output, asynchronous to REFERENCECLK.
REQ-009 REQ_RELOCK  in  1  level request to restart the sequence.
REQ-010 PLL_RESETB  out  1  to PLL RESETB; 0 holds PLL in reset.
REQ-011 PLL_BYPASS  out  1  to PLL BYPASS; 1 routes reference clock to PLL outputs.
REQ-012 CORE_RESETN  out  1  active-low reset for logic clocked by PLLOUTCORE/PLLOUTGLOBAL.
REQ-013 READY  out  1  high only in RUN.
REQ-014 FAULT  out  1  high only in FAULT.
REQ-015 LOCK_LOST  out  1  one-cycle pulse on lock loss in RUN.
REQ-016 RETRY_CNT  out  2  failed attempts in current sequence, saturating at 3.

Function
REQ-017 PLL_LOCK SHALL pass through a two-flop synchronizer; lock_s denotes its output; no other logic samples PLL_LOCK.
REQ-018 States SHALL be HOLD, WAIT_LOCK, SETTLE, RUN, FAULT; all outputs registered, decoded from state.
REQ-019 HOLD: PLL_RESETB=0, CORE_RESETN=0; after exactly RESET_HOLD_CYCLES cycles go to WAIT_LOCK, cycle counter cleared.
REQ-020 WAIT_LOCK: PLL_RESETB=1; on LOCK_FILTER_CYCLES consecutive lock_s=1 go to SETTLE; counter restarts on any lock_s=0.
REQ-021 WAIT_LOCK timeout (counter reaches LOCK_TIMEOUT_CYCLES): if RETRY_CNT<MAX_RETRIES increment RETRY_CNT and go HOLD, else go FAULT; lock qualification in the same cycle wins over timeout.
REQ-022 SETTLE: PLL_RESETB=1, CORE_RESETN=0; lock_s=0 at any cycle is a failed attempt handled exactly as REQ-021 timeout; after SETTLE_CYCLES cycles of lock_s=1 go RUN.
REQ-023 RUN: CORE_RESETN=1, READY=1, RETRY_CNT cleared on entry.
REQ-024 RUN, lock_s=0: go HOLD, pulse LOCK_LOST, CORE_RESETN low no later than 3 cycles after PLL_LOCK falls at the synchronizer input.
REQ-025 REQ_RELOCK=1 in RUN or FAULT: go HOLD with RETRY_CNT=0; ignored in HOLD, WAIT_LOCK, SETTLE.
REQ-026 RUN with lock loss and REQ_RELOCK same cycle: go HOLD, LOCK_LOST pulses, RETRY_CNT=0.
REQ-027 FAULT: PLL_BYPASS=1, PLL_RESETB=0, CORE_RESETN=0, FAULT=1; remains until REQ_RELOCK or RESET.
REQ-028 Counters SHALL be $clog2(max parameter + 1) bits, never wrap, cleared on every state change.

Reset
REQ-029 RESET=0 at a rising edge SHALL force next cycle: state HOLD, counters 0, synchronizer flops 0, PLL_RESETB=0, PLL_BYPASS=0, CORE_RESETN=0, READY=0, FAULT=0, LOCK_LOST=0, RETRY_CNT=0, from any state including mid-count.
REQ-030 After RESET returns to 1 the HOLD count SHALL start from zero (full RESET_HOLD_CYCLES).

Structure
REQ-031 Package pll_seq_pkg SHALL hold the state enum type and default parameter constants.
REQ-032 The synchronizer SHALL be sub-module sync_2ff (1-bit, reset value 0); the FSM and counters stay in pll_reset_sequencer.

Verification (params HOLD=4, TIMEOUT=32, FILTER=2, SETTLE=8, RETRIES=2)
REQ-033 Nominal: RESET released, PLL_LOCK high 10 cycles later -> PLL_RESETB rises after 4 cycles, READY and CORE_RESETN rise 2+2+8 cycles after PLL_LOCK, RETRY_CNT=0.
REQ-034 No lock: PLL_LOCK held 0 -> three HOLD/WAIT_LOCK attempts, RETRY_CNT 1 then 2, then FAULT=1, PLL_BYPASS=1, CORE_RESETN=0.
REQ-035 Lock loss in RUN: drop PLL_LOCK -> CORE_RESETN=0 within 3 cycles, one LOCK_LOST pulse, PLL_RESETB low 4 cycles, normal re-lock.
REQ-036 Glitch: PLL_LOCK high 1 cycle then low in WAIT_LOCK -> no SETTLE entry; lock drop at SETTLE cycle 5 -> RETRY_CNT=1, HOLD.
REQ-037 Recovery: REQ_RELOCK pulse in FAULT -> HOLD, PLL_BYPASS=0, RETRY_CNT=0; RESET=0 asserted mid-SETTLE -> all outputs at reset values next cycle.
